// File: rtl/regfile_mp.sv
// Multi-port register file: two async read ports, two sync write ports (B wins on collision),
// optional write-to-read bypass and a per-register busy scoreboard. Register 0 reads as zero.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              any_busy
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wr_a;
    logic              wr_b;
    logic              byp_ok;

    assign wr_a   = we_a && (wa_a != '0);
    assign wr_b   = we_b && (wa_b != '0);
    assign byp_ok = BYPASS && !rst;

    // Clears first so that a same-cycle issue re-marks the register for its new producer.
    always_comb begin
        busy_nxt = busy;
        if (wr_a) busy_nxt[wa_a] = 1'b0;
        if (wr_b) busy_nxt[wa_b] = 1'b0;
        if (iss_en && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Port B is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_a) regs[wa_a] <= wd_a;
            if (wr_b) regs[wa_b] <= wd_b;
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (byp_ok && we_b && (wa_b == ra1))      rd1 = wd_b;
        else if (byp_ok && we_a && (wa_a == ra1)) rd1 = wd_a;
        if (ra1 == '0) rd1 = '0;
    end

    always_comb begin
        rd2 = regs[ra2];
        if (byp_ok && we_b && (wa_b == ra2))      rd2 = wd_b;
        else if (byp_ok && we_a && (wa_a == ra2)) rd2 = wd_a;
        if (ra2 == '0) rd2 = '0;
    end

    assign busy1    = busy[ra1];
    assign busy2    = busy[ra2];
    assign any_busy = |busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypass, no-bypass and a narrow 16x8 instance share one
// directed sequence; expectations are queued by the stimulus and checked by a negedge monitor.
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [4:0]  ra1 = '0, ra2 = '0, wa_a = '0, wa_b = '0, iss_addr = '0;
    logic [31:0] wd_a = '0, wd_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0, iss_en = 1'b0;

    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        busy1_0, busy2_0, any_busy_0, busy1_1, busy2_1, any_busy_1;

    logic [2:0]  s_ra1 = '0, s_ra2 = '0, s_wa_a = '0, s_wa_b = '0, s_iss_addr = '0;
    logic [15:0] s_wd_a = '0, s_wd_b = '0, s_rd1, s_rd2;
    logic        s_we_a = 1'b0, s_we_b = 1'b0, s_iss_en = 1'b0;
    logic        s_busy1, s_busy2, s_any_busy;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy1(busy1_0), .busy2(busy2_0), .any_busy(any_busy_0));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy1(busy1_1), .busy2(busy2_1), .any_busy(any_busy_1));

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)) u_small (
        .clk(clk), .rst(rst), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
        .we_a(s_we_a), .wa_a(s_wa_a), .wd_a(s_wd_a), .we_b(s_we_b), .wa_b(s_wa_b), .wd_b(s_wd_b),
        .iss_en(s_iss_en), .iss_addr(s_iss_addr),
        .busy1(s_busy1), .busy2(s_busy2), .any_busy(s_any_busy));

    typedef struct {
        int          dut;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // dut: 0 bypass, 1 no-bypass, 2 small; sig: 0 rd1, 1 rd2, 2 busy1, 3 busy2, 4 any_busy
    function automatic logic [31:0] actual(int d, int s);
        logic [31:0] r;
        r = '0;
        case (d)
            0: case (s) 0: r = rd1_0; 1: r = rd2_0; 2: r = {31'd0, busy1_0};
                        3: r = {31'd0, busy2_0}; default: r = {31'd0, any_busy_0}; endcase
            1: case (s) 0: r = rd1_1; 1: r = rd2_1; 2: r = {31'd0, busy1_1};
                        3: r = {31'd0, busy2_1}; default: r = {31'd0, any_busy_1}; endcase
            default: case (s) 0: r = {16'd0, s_rd1}; 1: r = {16'd0, s_rd2}; 2: r = {31'd0, s_busy1};
                        3: r = {31'd0, s_busy2}; default: r = {31'd0, s_any_busy}; endcase
        endcase
        return r;
    endfunction

    task automatic expect_v(int d, int s, logic [31:0] v, string name);
        exp_t e;
        e.dut = d; e.sig = s; e.val = v; e.name = name;
        q.push_back(e);
    endtask

    // Apply the next cycle's inputs just after the active edge, enables defaulting to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 1'b0; we_a = 1'b0; we_b = 1'b0; iss_en = 1'b0;
        s_we_a = 1'b0; s_we_b = 1'b0; s_iss_en = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.dut, e.sig);
                checks++;
                if (a !== e.val) begin
                    errors++;
                    $display("FAIL %s (dut %0d): got 0x%08h, expected 0x%08h", e.name, e.dut, a, e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL watchdog: sequence did not complete, checks=%0d errors=%0d", checks, errors);
            $fatal(1, "timeout");
        end
    end

    initial begin : stimulus
        // c1: out of reset
        cyc(); ra1 = 5'd5; ra2 = 5'd6;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 0, 32'h0, "reset_rd1");
            expect_v(d, 1, 32'h0, "reset_rd2");
            expect_v(d, 2, 32'h0, "reset_busy1");
            expect_v(d, 4, 32'h0, "reset_any_busy");
        end
        s_ra1 = 3'd7;
        expect_v(2, 0, 32'h0, "small_reset_rd1");

        // c2: write r5, same-cycle bypass only on the bypass instance
        cyc(); we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF; ra1 = 5'd5;
        expect_v(0, 0, 32'hDEADBEEF, "byp_a_rd1");
        expect_v(1, 0, 32'h0, "nobyp_a_rd1");
        s_we_a = 1'b1; s_wa_a = 3'd7; s_wd_a = 16'hFFFF; s_ra1 = 3'd7;
        expect_v(2, 0, 32'h0000FFFF, "small_byp_r7");

        // c3: reset with in-flight write and issue; bypass suppressed, stored values shown
        cyc(); rst = 1'b1; we_a = 1'b1; wa_a = 5'd6; wd_a = 32'h55; iss_en = 1'b1; iss_addr = 5'd3;
        ra1 = 5'd5; ra2 = 5'd6;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 0, 32'hDEADBEEF, "rst_cycle_stored_r5");
            expect_v(d, 1, 32'h0, "rst_cycle_no_bypass_r6");
        end
        expect_v(2, 0, 32'h0000FFFF, "small_stored_r7");

        // c4: everything cleared
        cyc(); ra1 = 5'd5; ra2 = 5'd6;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 0, 32'h0, "post_rst_r5");
            expect_v(d, 1, 32'h0, "post_rst_r6");
            expect_v(d, 4, 32'h0, "post_rst_any_busy");
        end
        expect_v(2, 0, 32'h0, "small_post_rst_r7");

        // c5: writes and issue to r0 have no effect
        cyc(); we_a = 1'b1; wa_a = 5'd0; wd_a = 32'h1234; ra1 = 5'd0; iss_en = 1'b1; iss_addr = 5'd0;
        for (int d = 0; d < 2; d++) expect_v(d, 0, 32'h0, "r0_same_cycle");

        // c6
        cyc(); ra1 = 5'd0;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 0, 32'h0, "r0_next_cycle");
            expect_v(d, 2, 32'h0, "r0_busy1");
            expect_v(d, 4, 32'h0, "r0_any_busy");
        end

        // c7: collision on r7, port B wins
        cyc(); we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11; we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h22;
        ra1 = 5'd7;
        expect_v(0, 0, 32'h22, "collision_bypass");
        expect_v(1, 0, 32'h0, "collision_nobyp_old");

        // c8
        cyc(); ra1 = 5'd7;
        for (int d = 0; d < 2; d++) expect_v(d, 0, 32'h22, "collision_stored");

        // c9: independent dual writes
        cyc(); we_a = 1'b1; wa_a = 5'd1; wd_a = 32'hA; we_b = 1'b1; wa_b = 5'd2; wd_b = 32'hB;
        ra1 = 5'd1; ra2 = 5'd2;
        expect_v(0, 0, 32'hA, "dual_byp_rd1");
        expect_v(0, 1, 32'hB, "dual_byp_rd2");
        expect_v(1, 0, 32'h0, "dual_nobyp_rd1");
        expect_v(1, 1, 32'h0, "dual_nobyp_rd2");
        s_we_b = 1'b1; s_wa_b = 3'd7; s_wd_b = 16'h1234;

        // c10
        cyc(); ra1 = 5'd1; ra2 = 5'd2;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 0, 32'hA, "dual_stored_rd1");
            expect_v(d, 1, 32'hB, "dual_stored_rd2");
        end
        s_ra1 = 3'd7; s_ra2 = 3'd3;
        expect_v(2, 0, 32'h00001234, "small_r7_rewritten");
        expect_v(2, 1, 32'h0, "small_r3");

        // c11: issue r9
        cyc(); iss_en = 1'b1; iss_addr = 5'd9; ra1 = 5'd9; ra2 = 5'd9;
        expect_v(0, 2, 32'h0, "issue_not_yet_busy");
        expect_v(0, 4, 32'h0, "issue_not_yet_any");

        // c12
        cyc(); ra1 = 5'd9; ra2 = 5'd9;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 2, 32'h1, "issued_busy1");
            expect_v(d, 3, 32'h1, "issued_busy2");
            expect_v(d, 4, 32'h1, "issued_any_busy");
        end

        // c13: write and re-issue r9 together; busy not bypassed
        cyc(); we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h99; iss_en = 1'b1; iss_addr = 5'd9; ra1 = 5'd9;
        expect_v(0, 2, 32'h1, "wr_iss_busy_same");
        expect_v(0, 0, 32'h99, "wr_iss_byp_data");

        // c14: set wins over clear
        cyc(); ra1 = 5'd9;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 2, 32'h1, "set_wins_busy1");
            expect_v(d, 4, 32'h1, "set_wins_any");
            expect_v(d, 0, 32'h99, "set_wins_data");
        end

        // c15: write r9 alone through port B; clear only after the edge
        cyc(); we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h77; ra1 = 5'd9;
        expect_v(0, 2, 32'h1, "clear_pending_busy1");

        // c16
        cyc(); ra1 = 5'd9;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 2, 32'h0, "cleared_busy1");
            expect_v(d, 4, 32'h0, "cleared_any");
            expect_v(d, 0, 32'h77, "cleared_data");
        end

        // c17: issue r4, then reset drops it
        cyc(); iss_en = 1'b1; iss_addr = 5'd4;
        cyc(); rst = 1'b1; ra1 = 5'd4;
        expect_v(0, 2, 32'h1, "busy_before_rst");
        cyc(); ra1 = 5'd4; ra2 = 5'd7;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 2, 32'h0, "busy_lost_on_rst");
            expect_v(d, 4, 32'h0, "any_lost_on_rst");
            expect_v(d, 1, 32'h0, "r7_lost_on_rst");
        end

        cyc();
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the pipelined CPU datapath. It is the successor to the single-port-write CPU register file. It provides two asynchronous read ports and two synchronous write ports (A: ALU writeback, B: load writeback). Added over the previous generation: synchronous clear, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection. Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; register count NREG = 2**ADDR_W
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored value only

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  read data, port 1 (combinational)
rd2  out  DATA_W  read data, port 2 (combinational)
we_a  in  1  write enable, port A
wa_a  in  ADDR_W  write address, port A
wd_a  in  DATA_W  write data, port A
we_b  in  1  write enable, port B
wa_b  in  ADDR_W  write address, port B
wd_b  in  DATA_W  write data, port B
iss_en  in  1  issue: mark destination register busy
iss_addr  in  ADDR_W  destination register being issued
busy1  out  1  scoreboard bit of ra1 (combinational)
busy2  out  1  scoreboard bit of ra2 (combinational)
any_busy  out  1  OR of all scoreboard bits

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled at the rising edge of clk.
- Reset: at the clk edge with rst=1, all NREG registers are set to 0 and all busy bits are cleared. Writes and issues in that cycle are ignored. After reset: rd1=rd2=0, busy1=busy2=any_busy=0.
- Writes: at the clk edge, if we_x=1 and wa_x!=0, then reg[wa_x] <= wd_x. Writes to address 0 are discarded.
- Write collision: if we_a=we_b=1 and wa_a==wa_b, port B wins and port A's data is dropped.
- Reads:
  - rdN = 0 when raN==0, regardless of writes or bypass.
  - Otherwise, with BYPASS=1: if we_b=1 and wa_b==raN, rdN=wd_b. Else if we_a=1 and wa_a==raN, rdN=wd_a. Else rdN=reg[raN].
  - With BYPASS=0: rdN=reg[raN]. Written data becomes visible the cycle after the edge.
  - Bypass is suppressed while rst=1; rdN then shows the stored value.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - At the edge, a write (we_x=1, wa_x!=0) clears busy[wa_x].
  - At the same edge, iss_en=1 with iss_addr!=0 sets busy[iss_addr].
  - If a set and a clear target the same register in the same cycle, set wins: the new producer owns the register.
  - Issue to address 0 has no effect.
  - busyN = busy[raN]. busyN is not bypassed: a write in the current cycle does not clear busyN until after the edge.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. Write-to-busy-clear is 1 cycle.
- Widths: all data paths are DATA_W bits, with no sign extension or truncation. Addresses are unsigned and cover exactly NREG entries, so no out-of-range case exists.
- Reset mid-operation: any pending busy bits and any in-flight writes in the reset cycle are lost. The bench must not expect them to survive.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst for one cycle with we_a=1 wa_a=r6 -> afterwards rd(r5)=0, rd(r6)=0, any_busy=0.
- r0 hardwired: we_a=1 wa_a=0 wd_a=0x1234, ra1=0 -> rd1=0 in the same cycle and in the next cycle; iss_en with iss_addr=0 -> busy1=0.
- Bypass and collision: BYPASS=1, we_a=1 wa_a=r7 wd_a=0x11, we_b=1 wa_b=r7 wd_b=0x22, ra1=r7 -> rd1=0x22 in the same cycle and stored r7=0x22 next cycle. Repeat with BYPASS=0 -> rd1 shows the old value, then 0x22 next cycle.
- Dual independent writes: wa_a=r1 wd_a=0xA, wa_b=r2 wd_b=0xB -> next cycle ra1=r1 gives 0xA and ra2=r2 gives 0xB.
- Scoreboard: issue r9 -> next cycle busy1=1 (ra1=r9) and any_busy=1. Then write r9 together with issue r9 in the same cycle -> busy remains 1. Then write r9 alone -> busy1=0 and any_busy=0 next cycle.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> exactly 8 registers; write 0xFFFF to r7 and read back 0xFFFF.
